// File: rtl/gb80_oam_dma.sv
// gb80_oam_dma
//   OAM DMA controller and memory-bus arbiter between the gb80 CPU memory port
//   and system memory. A CPU write to REG_ADDR latches a source high byte; after
//   START_DELAY clocks the block copies XFER_LEN bytes from {src_hi,8'h00} to
//   DST_BASE, one byte per 4-clock machine cycle. While a copy is pending or
//   running the CPU is limited to HRAM (FF80-FFFE), whose accesses are slotted
//   into the two free phases of each machine cycle.
//
// State table
//   state   | meaning
//   S_IDLE  | no copy; CPU requests (other than REG_ADDR) pass straight to memory
//   S_START | copy requested; counting down START_DELAY clocks
//   S_XFER  | copying; phase 0 reads source, phase 2 writes OAM, 1/3 free for CPU
//
// Ports
//   i_clk, i_reset        clock, synchronous active-low reset
//   i_cpu_rd/wr/addr/wdata CPU request (rd and wr never together)
//   o_cpu_rdata           CPU read data, valid the clock after an accepted read
//   o_cpu_stall           combinational; CPU holds its request while high
//   o_mem_rd/wr/addr/wdata memory request
//   i_mem_rdata           memory read data, valid the clock after o_mem_rd
//   o_dma_active          high in S_START and S_XFER
//
// XFER_LEN must be in 1..256 (the byte index is 8 bits) and START_DELAY >= 1.

module gb80_oam_dma #(
  parameter int unsigned XFER_LEN    = 160,
  parameter logic [15:0] DST_BASE    = 16'hFE00,
  parameter logic [15:0] REG_ADDR    = 16'hFF46,
  parameter int unsigned START_DELAY = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_stall,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_dma_active
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  localparam int unsigned   DW         = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0] DELAY_LOAD = DW'(START_DELAY - 1);
  localparam logic [DW-1:0] DELAY_ONE  = DW'(1);
  localparam logic [7:0]    LAST_IDX   = 8'(XFER_LEN - 1);

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    src_hi_q, src_hi_d;
  logic [7:0]    reg_ff46_q, reg_ff46_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rd_pend_q, rd_pend_d;
  logic          dma_active_q, dma_active_d;

  logic cpu_req;
  logic reg_hit;
  logic hram_hit;
  logic dma_slot;
  logic cpu_fwd;
  logic cpu_blocked;

  // Request classification and bus mux
  always_comb begin
    cpu_req  = i_cpu_rd | i_cpu_wr;
    reg_hit  = (i_cpu_addr == REG_ADDR);
    hram_hit = (i_cpu_addr >= 16'hFF80) && (i_cpu_addr <= 16'hFFFE);
    dma_slot = (state_q == S_XFER) && !phase_q[0];

    case (state_q)
      S_IDLE:  cpu_fwd = cpu_req && !reg_hit;
      S_START: cpu_fwd = cpu_req && hram_hit;
      S_XFER:  cpu_fwd = cpu_req && hram_hit && phase_q[0];
      default: cpu_fwd = 1'b0;
    endcase

    cpu_blocked = (state_q != S_IDLE) && cpu_req && !reg_hit && !hram_hit;

    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = 16'h0000;
    o_mem_wdata = 8'h00;
    o_cpu_stall = 1'b0;

    // Everything is forced quiet while reset is held, including the
    // combinational CPU pass-through.
    if (i_reset) begin
      o_cpu_stall = (state_q == S_XFER) && cpu_req && hram_hit && !phase_q[0];
      if (dma_slot) begin
        if (phase_q == 2'd0) begin
          o_mem_rd   = 1'b1;
          o_mem_addr = {src_hi_q, idx_q};
        end else begin
          o_mem_wr    = 1'b1;
          o_mem_addr  = DST_BASE + {8'h00, idx_q};
          o_mem_wdata = byte_q;
        end
      end else if (cpu_fwd) begin
        o_mem_rd    = i_cpu_rd;
        o_mem_wr    = i_cpu_wr;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    src_hi_d   = src_hi_q;
    reg_ff46_d = reg_ff46_q;
    delay_d    = delay_q;
    byte_d     = byte_q;
    rd_pend_d  = 1'b0;
    // Memory data arrives the clock after the strobe; fold it into the
    // holding register so the CPU keeps seeing it afterwards.
    rdata_d    = rd_pend_q ? i_mem_rdata : rdata_q;

    case (state_q)
      S_START: begin
        if (delay_q == '0) begin
          state_d = S_XFER;
          phase_d = 2'd0;
          idx_d   = 8'h00;
        end else begin
          delay_d = delay_q - DELAY_ONE;
        end
      end
      S_XFER: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          byte_d = i_mem_rdata;
        end
        if (phase_q == 2'd2) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            phase_d = 2'd0;
            idx_d   = 8'h00;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    // A register write restarts from scratch in any state, and takes priority
    // over the end-of-copy return to idle.
    if (i_cpu_wr && reg_hit) begin
      reg_ff46_d = i_cpu_wdata;
      src_hi_d   = i_cpu_wdata;
      state_d    = S_START;
      delay_d    = DELAY_LOAD;
      phase_d    = 2'd0;
      idx_d      = 8'h00;
    end

    if (i_cpu_rd) begin
      if (reg_hit) begin
        rdata_d = reg_ff46_q;
      end else if (cpu_fwd) begin
        rd_pend_d = 1'b1;
      end else if (cpu_blocked) begin
        rdata_d = 8'hFF;
      end
    end

    dma_active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      phase_q      <= 2'd0;
      idx_q        <= 8'h00;
      src_hi_q     <= 8'h00;
      reg_ff46_q   <= 8'h00;
      delay_q      <= '0;
      byte_q       <= 8'h00;
      rdata_q      <= 8'h00;
      rd_pend_q    <= 1'b0;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      src_hi_q     <= src_hi_d;
      reg_ff46_q   <= reg_ff46_d;
      delay_q      <= delay_d;
      byte_q       <= byte_d;
      rdata_q      <= rdata_d;
      rd_pend_q    <= rd_pend_d;
      dma_active_q <= dma_active_d;
    end
  end

  assign o_cpu_rdata  = !i_reset ? 8'h00 : (rd_pend_q ? i_mem_rdata : rdata_q);
  assign o_dma_active = dma_active_q & i_reset;

endmodule

// File: tb/tb_gb80_oam_dma.sv
module tb_gb80_oam_dma;
  localparam int D = 4;
  localparam int N = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        dma_active;

  always #5 clk = ~clk;

  gb80_oam_dma dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_dma_active(dma_active)
  );

  // Synchronous-read system memory and bus-activity logs
  typedef struct { int c; logic [15:0] a; logic [7:0] d; } acc_t;
  logic [7:0] mem [0:65535];
  acc_t wlog[$];
  acc_t rlog[$];
  int cyc = 0;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rlog.push_back('{cyc, mem_addr, 8'h00});
    end
    if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wlog.push_back('{cyc, mem_addr, mem_wdata});
    end
    cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_src [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic cpu_idle();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic cpu_drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic snap(input logic [7:0] src);
    for (int k = 0; k < N; k++) ref_src[k] = mem[{src, 8'h00} + 16'(k)];
  endtask

  // Reference: byte k is read at tf+4k and written to DST_BASE+k at tf+4k+2.
  task automatic verify_xfer(input string tag, input logic [7:0] src, input int tf, input int nbytes);
    int k;
    bit seen;
    k = 0;
    foreach (wlog[i]) begin
      if (wlog[i].a >= 16'hFE00 && wlog[i].a <= 16'hFE9F) begin
        if (k < nbytes) begin
          chk({tag, "_wcyc"}, wlog[i].c, tf + 4 * k + 2);
          chk({tag, "_waddr"}, wlog[i].a, 16'hFE00 + 16'(k));
          chk({tag, "_wdata"}, wlog[i].d, ref_src[k]);
        end
        k++;
      end
    end
    chk({tag, "_wcount"}, k, nbytes);
    seen = 0;
    foreach (rlog[i]) begin
      if (!seen && rlog[i].a[15:8] == src) begin
        seen = 1;
        chk({tag, "_rd0cyc"}, rlog[i].c, tf);
        chk({tag, "_rd0addr"}, rlog[i].a, {src, 8'h00});
      end
    end
    chk({tag, "_rd0seen"}, seen, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_end);
    for (int i = 0; i < 1000; i++) begin
      tick();
      #4;
      if (!dma_active) break;
    end
    chk({tag, "_end"}, cyc, exp_end);
  endtask

  typedef struct {
    logic rd, wr; logic [15:0] addr; logic [7:0] wd;
    logic e_rd, e_wr; logic [15:0] e_addr; logic [7:0] e_wd; logic [7:0] e_rdata;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, tf, c, w1, errs;
    logic p_rd, p_wr; logic [15:0] p_addr; logic [7:0] p_wd;
    bit pend, ev, started, hram, st;
    logic [7:0] ed;
    int slot;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < N; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hD100 + 16'(i)] = 8'(i * 7 + 3);
      mem[16'hE000 + 16'(i)] = 8'(i) ^ 8'hC3;
    end
    mem[16'hFF90] = 8'h3C;

    tbl[0] = '{1'b1, 1'b0, 16'hC000, 8'h00, 1'b1, 1'b0, 16'hC000, 8'h00, 8'h5A};
    tbl[1] = '{1'b1, 1'b0, 16'hC005, 8'h00, 1'b1, 1'b0, 16'hC005, 8'h00, 8'h5F};
    tbl[2] = '{1'b0, 1'b1, 16'h8000, 8'h11, 1'b0, 1'b1, 16'h8000, 8'h11, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 16'hFF46, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 16'hFF90, 8'h00, 1'b1, 1'b0, 16'hFF90, 8'h00, 8'h3C};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 16'hFF81, 8'h22, 1'b0, 1'b1, 16'hFF81, 8'h22, 8'h00};
    tbl[7] = '{1'b1, 1'b0, 16'hFF81, 8'h00, 1'b1, 1'b0, 16'hFF81, 8'h00, 8'h22};

    // Reset held with a CPU request present: everything stays quiet
    rst_n = 1'b0;
    cpu_drive(1'b1, 1'b0, 16'hC000, 8'h00);
    repeat (3) tick();
    #4;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_active", dma_active, 0);
    chk("rst_rdata", cpu_rdata, 0);
    tick();
    rst_n = 1'b1;
    cpu_idle();
    #4;
    chk("rel_mem_rd", mem_rd, 0);
    chk("rel_mem_wr", mem_wr, 0);
    chk("rel_mem_addr", mem_addr, 0);
    chk("rel_active", dma_active, 0);
    chk("rel_rdata", cpu_rdata, 0);

    // Idle pass-through table
    for (int i = 0; i < 8; i++) begin
      tick();
      cpu_drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
      #4;
      if (i > 0 && tbl[i-1].rd) chk($sformatf("tbl%0d_rdata", i-1), cpu_rdata, tbl[i-1].e_rdata);
      chk($sformatf("tbl%0d_rd", i), mem_rd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_wr", i), mem_wr, tbl[i].e_wr);
      chk($sformatf("tbl%0d_stall", i), cpu_stall, 0);
      if (tbl[i].e_rd || tbl[i].e_wr) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_wr) chk($sformatf("tbl%0d_wd", i), mem_wdata, tbl[i].e_wd);
    end
    tick();
    cpu_idle();
    #4;
    chk("tbl7_rdata", cpu_rdata, tbl[7].e_rdata);

    // Transfer A: plain copy from C0, full timing check
    tick();
    snap(8'hC0);
    wlog.delete(); rlog.delete();
    cpu_drive(1'b0, 1'b1, 16'hFF46, 8'hC0);
    w0 = cyc;
    #4;
    chk("a_reg_not_fwd", mem_wr, 0);
    chk("a_reg_stall", cpu_stall, 0);
    chk("a_active_pre", dma_active, 0);
    tick();
    cpu_idle();
    #4;
    chk("a_active_rise", dma_active, 1);
    wait_done("a", w0 + D + 4 * N);
    verify_xfer("a", 8'hC0, w0 + 1 + D, N);

    // Transfer B: CPU interaction, then restart at idx 50 with source D1
    tick();
    wlog.delete(); rlog.delete();
    cpu_drive(1'b0, 1'b1, 16'hFF46, 8'hC0);
    w0 = cyc;
    tf = w0 + 1 + D;
    tick();
    cpu_idle();
    step_to(tf + 9);
    cpu_drive(1'b1, 1'b0, 16'hD000, 8'h00);
    #4;
    chk("b_blk_stall", cpu_stall, 0);
    chk("b_blk_rd", mem_rd, 0);
    chk("b_blk_wr", mem_wr, 0);
    tick();
    cpu_idle();
    #4;
    chk("b_blk_rdata", cpu_rdata, 8'hFF);
    tick();
    #4;
    chk("b_blk_hold", cpu_rdata, 8'hFF);
    step_to(tf + 20);
    cpu_drive(1'b0, 1'b1, 16'hFF90, 8'h33);
    #4;
    chk("b_hram_stall", cpu_stall, 1);
    chk("b_hram_nowr", mem_wr, 0);
    chk("b_dma_rd", mem_rd, 1);
    chk("b_dma_raddr", mem_addr, 16'hC005);
    tick();
    #4;
    chk("b_hram_stall1", cpu_stall, 0);
    chk("b_hram_wr", mem_wr, 1);
    chk("b_hram_addr", mem_addr, 16'hFF90);
    chk("b_hram_wd", mem_wdata, 8'h33);
    tick();
    cpu_idle();
    #4;
    chk("b_hram_mem", mem[16'hFF90], 8'h33);
    step_to(tf + 4 * 50 + 1);
    snap(8'hD1);
    wlog.delete(); rlog.delete();
    cpu_drive(1'b0, 1'b1, 16'hFF46, 8'hD1);
    w1 = cyc;
    #4;
    chk("b_rst_nowr", mem_wr, 0);
    tick();
    cpu_drive(1'b1, 1'b0, 16'hFF46, 8'h00);
    #4;
    chk("b_rst_active", dma_active, 1);
    tick();
    cpu_idle();
    #4;
    chk("b_reg_rdata", cpu_rdata, 8'hD1);
    wait_done("b", w1 + D + 4 * N);
    verify_xfer("b", 8'hD1, w1 + 1 + D, N);
    errs = 0;
    for (int k = 0; k < N; k++) if (mem[16'hFE00 + 16'(k)] !== ref_src[k]) errs++;
    chk("b_oam_contents", errs, 0);

    // Transfer E: register write coincides with the final OAM write
    tick();
    snap(8'hC0);
    cpu_drive(1'b0, 1'b1, 16'hFF46, 8'hC0);
    w0 = cyc;
    tf = w0 + 1 + D;
    tick();
    cpu_idle();
    c = tf + 4 * (N - 1) + 2;
    step_to(c);
    cpu_drive(1'b0, 1'b1, 16'hFF46, 8'hC0);
    #4;
    chk("e_last_wr", mem_wr, 1);
    chk("e_last_addr", mem_addr, 16'hFE9F);
    chk("e_last_data", mem_wdata, 8'hC5);
    tick();
    cpu_idle();
    wlog.delete(); rlog.delete();
    #4;
    chk("e_active1", dma_active, 1);
    tick();
    #4;
    chk("e_active2", dma_active, 1);
    wait_done("e", c + D + 4 * N);
    verify_xfer("e", 8'hC0, c + 1 + D, N);

    // Transfer C: random CPU traffic, then reset at idx 80
    tick();
    snap(8'hE0);
    wlog.delete(); rlog.delete();
    cpu_drive(1'b0, 1'b1, 16'hFF46, 8'hE0);
    w0 = cyc;
    tf = w0 + 1 + D;
    pend = 0; ev = 0; ed = 8'h00;
    p_rd = 0; p_wr = 0; p_addr = 16'h0000; p_wd = 8'h00;
    while (cyc < tf + 300) begin
      tick();
      if (!pend) begin
        p_rd = 0; p_wr = 0; p_addr = 16'h0000; p_wd = 8'h00;
        if (cyc < tf + 292) begin
          case ($urandom_range(0, 6))
            1, 2: begin p_rd = 1; p_addr = 16'($urandom_range(16'hFF80, 16'hFFFE)); end
            3:    begin p_wr = 1; p_addr = 16'($urandom_range(16'hFF80, 16'hFFFE)); p_wd = 8'($urandom); end
            4:    begin p_rd = 1; p_addr = 16'($urandom_range(16'h8000, 16'hBFFF)); end
            5:    begin p_wr = 1; p_addr = 16'($urandom_range(16'h8000, 16'hBFFF)); p_wd = 8'($urandom); end
            6:    begin p_rd = 1; p_addr = 16'hFF46; end
            default: ;
          endcase
        end
      end
      cpu_drive(p_rd, p_wr, p_addr, p_wd);
      #4;
      if (ev) chk("rnd_rdata", cpu_rdata, ed);
      ev = 0;
      pend = 0;
      started = (cyc >= tf);
      slot = started ? (cyc - tf) % 4 : 0;
      hram = (p_addr >= 16'hFF80) && (p_addr <= 16'hFFFE);
      if (p_rd || p_wr) begin
        if (p_addr == 16'hFF46) begin
          chk("rnd_reg_stall", cpu_stall, 0);
          ev = 1; ed = 8'hE0;
        end else if (hram) begin
          st = started && (slot == 0 || slot == 2);
          chk("rnd_stall", cpu_stall, st);
          if (st) begin
            chk("rnd_held_off", mem_addr == p_addr, 0);
            pend = 1;
          end else begin
            chk("rnd_fwd_rd", mem_rd, p_rd);
            chk("rnd_fwd_wr", mem_wr, p_wr);
            chk("rnd_fwd_addr", mem_addr, p_addr);
            if (p_wr) chk("rnd_fwd_wd", mem_wdata, p_wd);
            if (p_rd) begin ev = 1; ed = mem[p_addr]; end
          end
        end else begin
          chk("rnd_blk_stall", cpu_stall, 0);
          if (!started || slot[0]) chk("rnd_blk_bus", mem_rd | mem_wr, 0);
          if (p_rd) begin ev = 1; ed = 8'hFF; end
        end
      end
    end
    tick();
    cpu_idle();
    step_to(tf + 4 * 80);
    rst_n = 1'b0;
    #4;
    chk("c_rst_rd", mem_rd, 0);
    chk("c_rst_active", dma_active, 0);
    chk("c_rst_stall", cpu_stall, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    step_to(cyc + 700);
    #4;
    chk("c_post_active", dma_active, 0);
    verify_xfer("c", 8'hE0, tf, 80);
    tick();
    cpu_drive(1'b1, 1'b0, 16'hFF46, 8'h00);
    tick();
    cpu_idle();
    #4;
    chk("c_post_reg", cpu_rdata, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
